// File: rtl/mempool_pkg.sv
// Shared MemPool TCDM payload types used by the core-side shims.
package mempool_pkg;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [DataWidth-1:0] data_t;
  typedef logic [StrbWidth-1:0] strb_t;

endpackage

// File: rtl/tcdm_resp_fifo.sv
// Response FIFO: register-array storage, head driven from storage (no
// combinational path from push side), push+pop allowed at any occupancy.
module tcdm_resp_fifo #(
  parameter int unsigned Depth   = 4,
  parameter type         dtype_t = logic [31:0]
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  dtype_t                       data_i,
  input  logic                         pop_i,
  output dtype_t                       data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(Depth+1)-1:0]   usage_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned UsgW = $clog2(Depth + 1);

  dtype_t            mem [Depth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [UsgW-1:0]   usage_q;
  logic              do_push, do_pop;

  // A pop frees a slot in the same cycle, so a full FIFO may still take a push.
  assign do_pop  = pop_i & (usage_q != '0);
  assign do_push = push_i & ((usage_q != UsgW'(Depth)) | do_pop);

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Payload storage; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= data_i;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   usage_q <= usage_q + UsgW'(1);
        2'b01:   usage_q <= usage_q - UsgW'(1);
        default: usage_q <= usage_q;
      endcase
    end
  end

  assign data_o  = mem[rd_ptr_q];
  assign full_o  = (usage_q == UsgW'(Depth));
  assign empty_o = (usage_q == '0);
  assign usage_o = usage_q;

endmodule

// File: rtl/tcdm_outstanding_limiter.sv
// Per-core credit limiter between a TCDM master port and the interconnect.
// Requests pass combinationally while credits remain; responses are always
// accepted and buffered, so the interconnect response path never stalls.
// Optional build macro: TCDM_LIMITER_STATS_EN adds stall_cnt_o and
// peak_outstanding_o.
module tcdm_outstanding_limiter
  import mempool_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                core_req_valid_i,
  output logic                core_req_ready_o,
  input  addr_t               core_req_tgt_addr_i,
  input  logic                core_req_wen_i,
  input  data_t               core_req_wdata_i,
  input  strb_t               core_req_be_i,
  output logic                core_resp_valid_o,
  input  logic                core_resp_ready_i,
  output data_t               core_resp_rdata_o,
  output logic                ico_req_valid_o,
  input  logic                ico_req_ready_i,
  output addr_t               ico_req_tgt_addr_o,
  output logic                ico_req_wen_o,
  output data_t               ico_req_wdata_o,
  output strb_t               ico_req_be_o,
  input  logic                ico_resp_valid_i,
  output logic                ico_resp_ready_o,
  input  data_t               ico_resp_rdata_i,
  output logic [CntWidth-1:0] outstanding_o,
  output logic                err_o
`ifdef TCDM_LIMITER_STATS_EN
  ,
  output logic [31:0]         stall_cnt_o,
  output logic [CntWidth-1:0] peak_outstanding_o
`endif
);

  logic [CntWidth-1:0]                  cnt_q, cnt_d;
  logic                                 cnt_err, err_q;
  logic                                 credit_ok, req_hs, resp_hs;
  logic                                 resp_in, resp_err, fifo_push;
  logic                                 fifo_full, fifo_empty;
  logic [$clog2(MaxOutstanding+1)-1:0]  fifo_usage_unused;

  // Request path: pure gating, payload straight through.
  assign credit_ok          = (cnt_q < CntWidth'(MaxOutstanding));
  assign ico_req_valid_o    = core_req_valid_i & credit_ok;
  assign core_req_ready_o   = ico_req_ready_i & credit_ok;
  assign ico_req_tgt_addr_o = core_req_tgt_addr_i;
  assign ico_req_wen_o      = core_req_wen_i;
  assign ico_req_wdata_o    = core_req_wdata_i;
  assign ico_req_be_o       = core_req_be_i;

  assign req_hs  = ico_req_valid_o & ico_req_ready_i;
  assign resp_hs = core_resp_valid_o & core_resp_ready_i;

  // Response side is held off only while reset is asserted.
  assign ico_resp_ready_o = ~rst_i;
  assign resp_in          = ico_resp_valid_i & ico_resp_ready_o;
  // Orphan responses (nothing outstanding) or overflow are dropped and flagged.
  assign resp_err         = resp_in & ((cnt_q == '0) | (fifo_full & ~resp_hs));
  assign fifo_push        = resp_in & ~resp_err;

  tcdm_resp_fifo #(
    .Depth   (MaxOutstanding),
    .dtype_t (data_t)
  ) i_resp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (fifo_push),
    .data_i  (ico_resp_rdata_i),
    .pop_i   (resp_hs),
    .data_o  (core_resp_rdata_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (fifo_usage_unused)
  );

  assign core_resp_valid_o = ~fifo_empty;

  // Credit counter next state: saturating, any step past a bound is an error.
  always_comb begin
    cnt_d   = cnt_q;
    cnt_err = 1'b0;
    if (req_hs && !resp_hs) begin
      if (cnt_q == CntWidth'(MaxOutstanding)) cnt_err = 1'b1;
      else                                    cnt_d   = cnt_q + CntWidth'(1);
    end else if (!req_hs && resp_hs) begin
      if (cnt_q == '0) cnt_err = 1'b1;
      else             cnt_d   = cnt_q - CntWidth'(1);
    end
  end

  // Credit counter and sticky error flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_q | cnt_err | resp_err;
    end
  end

  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

`ifdef TCDM_LIMITER_STATS_EN
  logic [31:0]         stall_q;
  logic [CntWidth-1:0] peak_q;

  // Credit-stall cycle count (saturating) and high-water mark of usage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q <= '0;
      peak_q  <= '0;
    end else begin
      if (core_req_valid_i && !credit_ok && (stall_q != '1)) stall_q <= stall_q + 32'd1;
      if (cnt_d > peak_q) peak_q <= cnt_d;
    end
  end

  assign stall_cnt_o        = stall_q;
  assign peak_outstanding_o = peak_q;
`endif

endmodule

// File: tb/tb_tcdm_outstanding_limiter.sv
// Bench for tcdm_outstanding_limiter: directed scenarios with literal
// expectations, then randomized traffic against a queue-based model.
module tb_tcdm_outstanding_limiter;
  import mempool_pkg::*;

  localparam int MAX = 4;
  localparam int CW  = $clog2(MAX + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          core_req_valid = 1'b0, core_req_ready;
  addr_t         core_req_tgt_addr = '0;
  logic          core_req_wen = 1'b0;
  data_t         core_req_wdata = '0;
  strb_t         core_req_be = '0;
  logic          core_resp_valid, core_resp_ready = 1'b0;
  data_t         core_resp_rdata;
  logic          ico_req_valid, ico_req_ready = 1'b1;
  addr_t         ico_req_tgt_addr;
  logic          ico_req_wen;
  data_t         ico_req_wdata;
  strb_t         ico_req_be;
  logic          ico_resp_valid = 1'b0, ico_resp_ready;
  data_t         ico_resp_rdata = '0;
  logic [CW-1:0] outstanding;
  logic          err;
`ifdef TCDM_LIMITER_STATS_EN
  logic [31:0]   stall_cnt;
  logic [CW-1:0] peak_outstanding;
`endif

  tcdm_outstanding_limiter #(.MaxOutstanding(MAX)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .core_req_valid_i    (core_req_valid),
    .core_req_ready_o    (core_req_ready),
    .core_req_tgt_addr_i (core_req_tgt_addr),
    .core_req_wen_i      (core_req_wen),
    .core_req_wdata_i    (core_req_wdata),
    .core_req_be_i       (core_req_be),
    .core_resp_valid_o   (core_resp_valid),
    .core_resp_ready_i   (core_resp_ready),
    .core_resp_rdata_o   (core_resp_rdata),
    .ico_req_valid_o     (ico_req_valid),
    .ico_req_ready_i     (ico_req_ready),
    .ico_req_tgt_addr_o  (ico_req_tgt_addr),
    .ico_req_wen_o       (ico_req_wen),
    .ico_req_wdata_o     (ico_req_wdata),
    .ico_req_be_o        (ico_req_be),
    .ico_resp_valid_i    (ico_resp_valid),
    .ico_resp_ready_o    (ico_resp_ready),
    .ico_resp_rdata_i    (ico_resp_rdata),
    .outstanding_o       (outstanding),
    .err_o               (err)
`ifdef TCDM_LIMITER_STATS_EN
    ,
    .stall_cnt_o         (stall_cnt),
    .peak_outstanding_o  (peak_outstanding)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", nm, got, exp, $time);
    end
  endtask

  // Behavioural model: credit usage, queue of buffered responses, sticky error.
  int    m_outs  = 0;
  data_t m_q[$];
  bit    m_err   = 0;
  int    m_stall = 0;
  int    m_peak  = 0;
  bit    m_rhs, m_pop, m_push;

  always @(posedge clk) begin
    if (rst) begin
      m_outs = 0; m_q.delete(); m_err = 0; m_stall = 0; m_peak = 0;
    end else begin
      m_rhs  = core_req_valid && (m_outs < MAX) && ico_req_ready;
      m_pop  = (m_q.size() > 0) && core_resp_ready;
      m_push = 0;
      if (core_req_valid && m_outs >= MAX) m_stall++;
      if (ico_resp_valid) begin
        if (m_outs == 0 || (m_q.size() == MAX && !m_pop)) m_err = 1;
        else m_push = 1;
      end
      if (m_pop)  void'(m_q.pop_front());
      if (m_push) m_q.push_back(ico_resp_rdata);
      if (m_rhs && !m_pop) m_outs++;
      else if (m_pop && !m_rhs) begin
        if (m_outs == 0) m_err = 1;
        else m_outs--;
      end
      if (m_outs > m_peak) m_peak = m_outs;
    end
  end

  // Every-cycle comparison of DUT outputs against the model, away from posedge.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_outstanding", outstanding, 0);
      chk("rst_resp_valid", core_resp_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_ico_resp_ready", ico_resp_ready, 0);
    end else begin
      chk("core_req_ready", core_req_ready, ico_req_ready && (m_outs < MAX));
      chk("ico_req_valid", ico_req_valid, core_req_valid && (m_outs < MAX));
      chk("ico_addr", ico_req_tgt_addr, core_req_tgt_addr);
      chk("ico_wen", ico_req_wen, core_req_wen);
      chk("ico_wdata", ico_req_wdata, core_req_wdata);
      chk("ico_be", ico_req_be, core_req_be);
      chk("resp_valid", core_resp_valid, m_q.size() > 0);
      if (m_q.size() > 0) chk("resp_rdata", core_resp_rdata, m_q[0]);
      chk("outstanding", outstanding, m_outs);
      chk("err", err, m_err);
      chk("ico_resp_ready", ico_resp_ready, 1);
`ifdef TCDM_LIMITER_STATS_EN
      chk("stall_cnt", stall_cnt, m_stall);
      chk("peak", peak_outstanding, m_peak);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic rst_pulse();
    rst = 1'b1; cyc(); rst = 1'b0;
  endtask

  int hs;
  logic r5;

  initial begin
    // Reset held for two cycles.
    cyc(); cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("lit_reset_outstanding", outstanding, 0);
    chk("lit_reset_err", err, 0);
    cyc();

    // Six back-to-back reads, no responses: four accepted, then blocked.
    core_req_valid = 1'b1; core_req_wen = 1'b0; ico_req_ready = 1'b1;
    hs = 0; r5 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      core_req_tgt_addr = addr_t'(32'h100 + 4 * i);
      @(negedge clk);
      if (core_req_ready) hs++;
      if (i == 4) r5 = core_req_ready;
      cyc();
    end
    @(negedge clk);
    chk("lit_handshakes", hs, 4);
    chk("lit_ready_cycle5", r5, 0);
    chk("lit_outstanding_full", outstanding, 4);

    // One response returns and is popped; credit frees on the pop edge.
    cyc();
    ico_resp_valid = 1'b1; ico_resp_rdata = 32'hDEAD_BEEF; core_resp_ready = 1'b1;
    @(negedge clk);
    chk("lit_resp_not_yet", core_resp_valid, 0);
    cyc();
    ico_resp_valid = 1'b0;
    @(negedge clk);
    chk("lit_resp_valid", core_resp_valid, 1);
    chk("lit_resp_data", core_resp_rdata, 32'hDEAD_BEEF);
    chk("lit_outs_before_pop", outstanding, 4);
    chk("lit_ready_before_pop", core_req_ready, 0);
    cyc();
    @(negedge clk);
    chk("lit_outs_after_pop", outstanding, 3);
    chk("lit_ready_after_pop", core_req_ready, 1);
    cyc();
    core_req_valid = 1'b0; core_resp_ready = 1'b0;
    @(negedge clk);
    chk("lit_outs_refill", outstanding, 4);

    // Four responses buffered while the core stalls, then drained in order.
    cyc();
    for (int k = 1; k <= 4; k++) begin
      ico_resp_valid = 1'b1; ico_resp_rdata = data_t'(k);
      @(negedge clk);
      chk("lit_ico_resp_ready_held", ico_resp_ready, 1);
      cyc();
    end
    ico_resp_valid = 1'b0; core_resp_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("lit_drain_valid", core_resp_valid, 1);
      chk("lit_drain_data", core_resp_rdata, k);
      cyc();
    end
    @(negedge clk);
    chk("lit_drain_outs", outstanding, 0);
    chk("lit_drain_empty", core_resp_valid, 0);

    // Simultaneous request handshake and response pop at outstanding=2.
    cyc();
    core_resp_ready = 1'b0; core_req_valid = 1'b1;
    cyc(); cyc();
    core_req_valid = 1'b0; ico_resp_valid = 1'b1; ico_resp_rdata = 32'h55;
    cyc();
    ico_resp_valid = 1'b0; core_req_valid = 1'b1; core_resp_ready = 1'b1;
    @(negedge clk);
    chk("lit_both_req_ready", core_req_ready, 1);
    chk("lit_both_resp_valid", core_resp_valid, 1);
    cyc();
    core_req_valid = 1'b0;
    @(negedge clk);
    chk("lit_both_outs", outstanding, 2);
    chk("lit_both_err", err, 0);
    cyc();
    ico_resp_valid = 1'b1; ico_resp_rdata = 32'h6; cyc();
    ico_resp_rdata = 32'h7; cyc();
    ico_resp_valid = 1'b0; cyc(); cyc(); cyc();
    @(negedge clk);
    chk("lit_clean_outs", outstanding, 0);

    // Orphan response with nothing outstanding: dropped, sticky error.
    cyc();
    ico_resp_valid = 1'b1; ico_resp_rdata = 32'h9;
    @(negedge clk);
    chk("lit_orphan_err_pre", err, 0);
    cyc();
    ico_resp_valid = 1'b0;
    @(negedge clk);
    chk("lit_orphan_err", err, 1);
    chk("lit_orphan_no_resp", core_resp_valid, 0);
    cyc(); cyc(); cyc();
    @(negedge clk);
    chk("lit_orphan_sticky", err, 1);

    // Reset mid-operation with outstanding=3 and two buffered responses.
    cyc();
    rst_pulse();
    core_resp_ready = 1'b0; core_req_valid = 1'b1;
    cyc(); cyc(); cyc();
    core_req_valid = 1'b0; ico_resp_valid = 1'b1; ico_resp_rdata = 32'hA;
    cyc();
    ico_resp_rdata = 32'hB;
    cyc();
    ico_resp_valid = 1'b0;
    @(negedge clk);
    chk("lit_pre_rst_outs", outstanding, 3);
    chk("lit_pre_rst_valid", core_resp_valid, 1);
    cyc();
    rst = 1'b1; #1;
    chk("lit_async_outs", outstanding, 0);
    chk("lit_async_valid", core_resp_valid, 0);
    chk("lit_async_ico_ready", ico_resp_ready, 0);
`ifdef TCDM_LIMITER_STATS_EN
    chk("lit_async_stall", stall_cnt, 0);
    chk("lit_async_peak", peak_outstanding, 0);
`endif
    cyc();
    rst = 1'b0;
    // A late response for a pre-reset request is an orphan.
    ico_resp_valid = 1'b1; ico_resp_rdata = 32'hC;
    cyc();
    ico_resp_valid = 1'b0;
    @(negedge clk);
    chk("lit_stale_resp_err", err, 1);
    cyc();
    rst_pulse();

    // Randomized legal traffic; responses only for requests still in flight.
    for (int n = 0; n < 3000; n++) begin
      core_req_valid    = ($urandom_range(0, 9) < 6);
      core_req_wen      = $urandom_range(0, 1) == 1;
      core_req_tgt_addr = addr_t'($urandom);
      core_req_wdata    = data_t'($urandom);
      core_req_be       = strb_t'($urandom);
      ico_req_ready     = ($urandom_range(0, 9) < 7);
      core_resp_ready   = ($urandom_range(0, 9) < 6);
      ico_resp_valid    = ((m_outs - m_q.size()) > 0) && ($urandom_range(0, 1) == 1);
      ico_resp_rdata    = data_t'($urandom);
      cyc();
    end
    core_req_valid = 1'b0; ico_resp_valid = 1'b0;
    @(negedge clk);
    chk("rand_no_err", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
